instr_fetch_unit: RTL and testbench

//  Requester side of the instruction-memory read interface: holds the PC, issues word reads to the

---
 rtl/instr_fetch_unit_pkg.sv | 21 ++
 rtl/instr_fetch_unit_fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   IFU_XLEN            : PC / instruction width carried in the fetch buffer
//   INSTR_MEM_TAG_WIDTH : width of the request/response epoch tag
//   fetch_entry_t       : one buffered {pc, instr} pair
//   align_word()        : clears the sub-word byte-offset bits of an address
package instr_fetch_unit_pkg;

    localparam int unsigned IFU_XLEN            = 32;
    localparam int unsigned INSTR_MEM_TAG_WIDTH = 2;

    typedef struct packed {
        logic [IFU_XLEN-1:0] pc;
        logic [IFU_XLEN-1:0] instr;
    } fetch_entry_t;

    // Word-align an address by masking bits [1:0].
    function automatic logic [IFU_XLEN-1:0] align_word(input logic [IFU_XLEN-1:0] addr);
        return addr & ~IFU_XLEN'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used as the fetch buffer.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   push, push_data     : write one entry (ignored while flush is high)
//   pop                 : remove the head entry (ignored when empty or flushing)
//   flush               : discard all contents
//   head                : current head entry (valid only when !empty)
//   count, full, empty  : occupancy status
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // Upstream credit logic must never push into a full buffer.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(do_push && full))
        else $error("fetch_fifo: push into full buffer");

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requester side of the instruction-memory read port.
// Holds the PC, issues one word read at a time, accepts epoch-tagged responses,
// buffers {pc, instr} pairs and presents them to decode with valid/ready.
// Ports:
//   clk, rst_n                              : clock, synchronous active-low reset
//   fetch_en                                : allow new requests
//   redirect_valid, redirect_pc             : flush and restart fetching at redirect_pc
//   mem_raddr, mem_rvalid, mem_rtag         : request to instruction memory
//   mem_rdata, mem_rvalid_in, mem_rtag_in   : response from instruction memory
//   if_valid, if_pc, if_instr, if_ready     : fetch buffer head towards decode
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN       = IFU_XLEN,
    parameter int unsigned     ADDR_WIDTH = 12,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           fetch_en,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    output logic [ADDR_WIDTH-1:0]          mem_raddr,
    output logic                           mem_rvalid,
    output logic [INSTR_MEM_TAG_WIDTH-1:0] mem_rtag,
    input  logic [XLEN-1:0]                mem_rdata,
    input  logic                           mem_rvalid_in,
    input  logic [INSTR_MEM_TAG_WIDTH-1:0] mem_rtag_in,
    output logic                           if_valid,
    output logic [XLEN-1:0]                if_pc,
    output logic [XLEN-1:0]                if_instr,
    input  logic                           if_ready
);

    localparam int unsigned TAG_W = INSTR_MEM_TAG_WIDTH;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  req_pc_q;
    logic [TAG_W-1:0] epoch_q;
    logic             inflight_q;

    logic             issue;
    logic             credit_ok;
    logic             resp_take;
    logic             fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_wdata;

    // An outstanding request reserves a buffer slot so its response always fits.
    assign credit_ok = (32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH;
    assign issue     = rst_n & fetch_en & ~redirect_valid & ~fifo_full & credit_ok;

    assign mem_rvalid = issue;
    assign mem_raddr  = pc_q[ADDR_WIDTH-1:0];
    assign mem_rtag   = epoch_q;

    // Response valid may be held high by memory; only a live, current-epoch request is accepted.
    assign resp_take  = inflight_q & mem_rvalid_in & (mem_rtag_in == epoch_q) & ~redirect_valid;
    assign fifo_wdata = '{pc: req_pc_q, instr: mem_rdata};

    assign if_valid = rst_n & ~fifo_empty;
    assign if_pc    = if_valid ? fifo_head.pc    : '0;
    assign if_instr = if_valid ? fifo_head.instr : '0;
    assign fifo_pop = if_valid & if_ready;

    // PC, epoch and outstanding-request tracking; redirect outranks issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= align_word(RESET_PC);
            req_pc_q   <= '0;
            epoch_q    <= '0;
            inflight_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= align_word(redirect_pc);
            epoch_q    <= epoch_q + TAG_W'(1);
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + XLEN'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (resp_take),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: 1-cycle-latency memory responder, queue-based
// reference model checked every cycle, a directed vector table, hand-written
// redirect / epoch-wrap / reset sequences and a randomized phase.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int unsigned AW    = 12;
    localparam int unsigned TW    = INSTR_MEM_TAG_WIDTH;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_en = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = '0;
    logic [AW-1:0] mem_raddr;
    logic          mem_rvalid;
    logic [TW-1:0] mem_rtag;
    logic [31:0]   resp_d = '0;
    logic          resp_v = 1'b0;
    logic [TW-1:0] resp_t = '0;
    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_instr;
    logic          if_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_raddr      (mem_raddr),
        .mem_rvalid     (mem_rvalid),
        .mem_rtag       (mem_rtag),
        .mem_rdata      (resp_d),
        .mem_rvalid_in  (resp_v),
        .mem_rtag_in    (resp_t),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory image: two fixed instructions, address-derived words elsewhere.
    function automatic logic [31:0] memval(input logic [AW-1:0] a);
        if (a == 12'h000) return 32'h0000_0013;
        if (a == 12'h004) return 32'h0010_0093;
        return {16'hC0DE, 4'h0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural PC, epoch, one outstanding request, queue buffer.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t          mq[$];
    logic [31:0]   m_pc = '0;
    logic [31:0]   m_inf_pc = '0;
    logic [TW-1:0] m_epoch = '0;
    bit            m_inf = 1'b0;

    // Memory responder state.
    bit            hold = 1'b0;
    bit            corrupt_en = 1'b0;
    logic          s_req;
    logic [AW-1:0] s_addr;
    logic [TW-1:0] s_tag;

    task automatic model_check();
        bit          e_v, e_rv;
        logic [31:0] e_pc, e_in;
        e_v  = rst_n && (mq.size() > 0);
        e_rv = rst_n && fetch_en && !redirect_valid && ((mq.size() + int'(m_inf)) < DEPTH);
        if (e_v) begin e_pc = mq[0].pc; e_in = mq[0].instr; end
        else     begin e_pc = '0;       e_in = '0;          end
        chk("model_mem_rvalid", 32'(mem_rvalid), 32'(e_rv));
        chk("model_if_valid",   32'(if_valid),   32'(e_v));
        chk("model_if_pc",      if_pc,           e_pc);
        chk("model_if_instr",   if_instr,        e_in);
        if (rst_n) begin
            chk("model_mem_raddr", 32'(mem_raddr), 32'(m_pc[AW-1:0]));
            chk("model_mem_rtag",  32'(mem_rtag),  32'(m_epoch));
        end
    endtask

    task automatic model_update();
        bit issue, took;
        if (!rst_n) begin
            m_pc = '0; m_epoch = '0; m_inf = 1'b0; mq.delete();
        end else if (redirect_valid) begin
            mq.delete();
            m_epoch = m_epoch + 1'b1;
            m_pc    = {redirect_pc[31:2], 2'b00};
            m_inf   = 1'b0;
        end else begin
            issue = fetch_en && ((mq.size() + int'(m_inf)) < DEPTH);
            took  = m_inf && resp_v && (resp_t == m_epoch);
            if (mq.size() > 0 && if_ready) void'(mq.pop_front());
            if (took) mq.push_back('{pc: m_inf_pc, instr: memval(m_inf_pc[AW-1:0])});
            if (issue) begin m_inf_pc = m_pc; m_pc = m_pc + 32'd4; m_inf = 1'b1; end
            else m_inf = 1'b0;
        end
    endtask

    task automatic mem_update();
        logic [TW-1:0] flip;
        flip = (corrupt_en && $urandom_range(0, 9) == 0) ? TW'(1) : TW'(0);
        if (s_req) begin
            resp_v = 1'b1;
            resp_d = memval(s_addr);
            resp_t = s_tag ^ flip;
        end else if (!hold) begin
            resp_v = 1'b0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
        s_req  = mem_rvalid;
        s_addr = mem_raddr;
        s_tag  = mem_rtag;
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
        mem_update();
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          start;
        bit          fe;
        bit          rdy;
        bit          e_mrv;
        logic [11:0] e_addr;
        bit          e_ifv;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[$];

    initial begin
        // Streaming from reset with decode always ready.
        tbl.push_back('{1, 1, 1, 1, 12'h000, 0, 32'h0});
        tbl.push_back('{0, 1, 1, 1, 12'h004, 0, 32'h0});
        tbl.push_back('{0, 1, 1, 1, 12'h008, 1, 32'h0});
        tbl.push_back('{0, 1, 1, 1, 12'h00C, 1, 32'h4});
        tbl.push_back('{0, 1, 1, 1, 12'h010, 1, 32'h8});
        // Decode stalled: four requests fill the buffer, then in-order drain.
        tbl.push_back('{1, 1, 0, 1, 12'h000, 0, 32'h0});
        tbl.push_back('{0, 1, 0, 1, 12'h004, 0, 32'h0});
        tbl.push_back('{0, 1, 0, 1, 12'h008, 1, 32'h0});
        tbl.push_back('{0, 1, 0, 1, 12'h00C, 1, 32'h0});
        tbl.push_back('{0, 1, 0, 0, 12'h010, 1, 32'h0});
        tbl.push_back('{0, 1, 0, 0, 12'h010, 1, 32'h0});
        tbl.push_back('{0, 1, 1, 0, 12'h010, 1, 32'h0});
        tbl.push_back('{0, 1, 1, 1, 12'h010, 1, 32'h4});
        tbl.push_back('{0, 1, 1, 1, 12'h014, 1, 32'h8});
        tbl.push_back('{0, 1, 1, 1, 12'h018, 1, 32'hC});
        tbl.push_back('{0, 1, 1, 1, 12'h01C, 1, 32'h10});

        foreach (tbl[i]) begin
            if (tbl[i].start) do_reset();
            fetch_en = tbl[i].fe;
            if_ready = tbl[i].rdy;
            sample();
            chk($sformatf("tbl%0d_mem_rvalid", i), 32'(mem_rvalid), 32'(tbl[i].e_mrv));
            chk($sformatf("tbl%0d_mem_raddr", i),  32'(mem_raddr),  32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_if_valid", i),   32'(if_valid),   32'(tbl[i].e_ifv));
            chk($sformatf("tbl%0d_if_pc", i),      if_pc,           tbl[i].e_ifv ? tbl[i].e_pc : 32'h0);
            chk($sformatf("tbl%0d_if_instr", i),   if_instr,
                tbl[i].e_ifv ? memval(tbl[i].e_pc[AW-1:0]) : 32'h0);
            advance();
        end

        // Redirect to 0x40 while 0x8 is in flight.
        do_reset();
        fetch_en = 1'b1; if_ready = 1'b0;
        repeat (3) cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        sample();
        chk("t3_no_issue_on_redirect", 32'(mem_rvalid), 32'h0);
        advance();
        redirect_valid = 1'b0;
        sample();
        chk("t3_target_addr", 32'(mem_raddr), 32'h40);
        chk("t3_epoch_inc",   32'(mem_rtag),  32'h1);
        chk("t3_flushed",     32'(if_valid),  32'h0);
        advance();
        sample();
        chk("t3_stale_dropped", 32'(if_valid), 32'h0);
        advance();
        sample();
        chk("t3_first_valid",  32'(if_valid), 32'h1);
        chk("t3_first_pc",     if_pc,         32'h40);
        advance();

        // Unaligned redirect target with simultaneous ready: no pop, buffer empty.
        repeat (4) cyc();
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h42;
        sample();
        chk("t4_head_present", 32'(if_valid), 32'h1);
        advance();
        redirect_valid = 1'b0;
        sample();
        chk("t4_aligned_addr", 32'(mem_raddr), 32'h40);
        chk("t4_flushed",      32'(if_valid),  32'h0);
        chk("t4_epoch",        32'(mem_rtag),  32'h2);
        advance();
        repeat (3) cyc();

        // 2^TW+1 back-to-back redirects: epoch wraps, last target wins.
        for (int i = 1; i <= (1 << TW) + 1; i++) begin
            redirect_valid = 1'b1;
            redirect_pc = 32'(i) * 32'h100;
            cyc();
        end
        redirect_valid = 1'b0;
        sample();
        chk("t5_last_target", 32'(mem_raddr), 32'h500);
        chk("t5_epoch_wrap",  32'(mem_rtag),  32'((2 + (1 << TW) + 1) % (1 << TW)));
        advance();
        cyc();
        sample();
        chk("t5_first_pc",    if_pc,    32'h500);
        chk("t5_first_instr", if_instr, memval(12'h500));
        advance();

        // Reset with 3 buffered entries, one in flight and response valid held high.
        do_reset();
        fetch_en = 1'b1; if_ready = 1'b0;
        repeat (4) cyc();
        hold = 1'b1; rst_n = 1'b0;
        sample();
        chk("t6_rst_if_valid",   32'(if_valid),   32'h0);
        chk("t6_rst_mem_rvalid", 32'(mem_rvalid), 32'h0);
        chk("t6_rst_if_pc",      if_pc,           32'h0);
        chk("t6_rst_if_instr",   if_instr,        32'h0);
        advance();
        rst_n = 1'b1; fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk($sformatf("t6_stale_not_pushed%0d", i), 32'(if_valid), 32'h0);
            chk($sformatf("t6_pc_reset%0d", i), 32'(mem_raddr), 32'h0);
            advance();
        end
        fetch_en = 1'b1; hold = 1'b0;
        sample();
        chk("t6_refetch_issue", 32'(mem_rvalid), 32'h1);
        advance();
        cyc();
        sample();
        chk("t6_refetch_pc",    if_pc,    32'h0);
        chk("t6_refetch_instr", if_instr, 32'h0000_0013);
        advance();

        // Randomized traffic checked by the reference model every cycle.
        corrupt_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) hold = ($urandom_range(0, 1) == 1);
            rst_n          = ($urandom_range(0, 399) != 0);
            fetch_en       = ($urandom_range(0, 7) != 0);
            if_ready       = ($urandom_range(0, 4) < 3);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
